// File: rtl/insn_decode_stage.sv
// insn_decode_stage: registered instruction-decode stage with a two-word
// extended-immediate form. It splits each word into opcode, utility bit,
// register field and a zero-extended immediate, and has valid/ready on both sides.
//
// Handshake: a beat transfers on a rising clk edge when valid and ready are both
// high. in_ready = !flush && (!out_valid || out_ready), so the output register
// drains and refills at full rate. The producer holds out_* stable while
// out_valid=1 and out_ready=0.
//
// Optional feature macro: INSN_DECODE_ILLEGAL_EN. When it is defined,
// out_illegal = ILLEGAL_MASK[opcode]. When it is not defined, out_illegal is 0.
module insn_decode_stage #(
    parameter int                    INSN_W       = 8,
    parameter int                    OPC_W        = 4,
    parameter int                    REG_W        = 3,
    parameter int                    IMM_W        = 8,
    parameter logic [OPC_W-1:0]      EXT_OPC      = 4'hC,
    parameter logic [(1<<OPC_W)-1:0] ILLEGAL_MASK = 16'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSN_W-1:0] in_insn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opcode,
    output logic              out_util,
    output logic [REG_W-1:0]  out_reg,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_ext,
    output logic              out_illegal,
    output logic              dbg_state
);

    // Check the field layout and the immediate width when the design elaborates.
    if (INSN_W != OPC_W + 1 + REG_W) begin : g_bad_insn_w
        $error("insn_decode_stage: INSN_W must equal OPC_W+1+REG_W");
    end
    if (IMM_W < INSN_W) begin : g_bad_imm_w
        $error("insn_decode_stage: IMM_W must be >= INSN_W");
    end

    typedef enum logic {S_OP = 1'b0, S_EXT = 1'b1} state_t;

    state_t             state;
    logic [OPC_W-1:0]   held_opc;
    logic               held_util;
    logic [REG_W-1:0]   held_reg;

    logic [OPC_W-1:0]   f_opc;
    logic               f_util;
    logic [REG_W-1:0]   f_reg;
    logic [IMM_W-1:0]   short_imm;
    logic [IMM_W-1:0]   ext_imm;
    logic               accept;

    function automatic logic illegal_of(input logic [OPC_W-1:0] opc);
`ifdef INSN_DECODE_ILLEGAL_EN
        return ILLEGAL_MASK[opc];
`else
        return 1'b0;
`endif
    endfunction

    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    // Split the incoming word into fields and form both candidate immediates.
    always_comb begin
        f_opc     = in_insn[INSN_W-1 -: OPC_W];
        f_util    = in_insn[REG_W];
        f_reg     = in_insn[REG_W-1:0];
        short_imm = '0;
        ext_imm   = '0;
        ext_imm[INSN_W-1:0] = in_insn;
        // INC2 class: top two opcode bits are 11 and the low two bits are not 00.
        if (f_opc[OPC_W-1 -: 2] == 2'b11 && f_opc[1:0] != 2'b00) begin
            short_imm = IMM_W'(2);
        end else begin
            short_imm[REG_W:0] = {f_util, f_reg};
        end
    end

    // Decode FSM and output register. Flush takes priority over every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_OP;
            held_opc    <= '0;
            held_util   <= 1'b0;
            held_reg    <= '0;
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_util    <= 1'b0;
            out_reg     <= '0;
            out_imm     <= '0;
            out_ext     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            state     <= S_OP;
            out_valid <= 1'b0;
        end else if (accept && state == S_OP && f_opc != EXT_OPC) begin
            out_valid   <= 1'b1;
            out_opcode  <= f_opc;
            out_util    <= f_util;
            out_reg     <= f_reg;
            out_imm     <= short_imm;
            out_ext     <= 1'b0;
            out_illegal <= illegal_of(f_opc);
        end else if (accept && state == S_OP) begin
            // First beat of an extended op: park the fields and await the immediate.
            state     <= S_EXT;
            held_opc  <= f_opc;
            held_util <= f_util;
            held_reg  <= f_reg;
            if (out_ready) out_valid <= 1'b0;
        end else if (accept) begin
            state       <= S_OP;
            out_valid   <= 1'b1;
            out_opcode  <= held_opc;
            out_util    <= held_util;
            out_reg     <= held_reg;
            out_imm     <= ext_imm;
            out_ext     <= 1'b1;
            out_illegal <= illegal_of(held_opc);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_insn_decode_stage.sv
// Directed bench for insn_decode_stage: reset, field decode, INC2 immediate,
// extended-immediate pairs, backpressure, flush, reset mid-EXT, streaming and
// the illegal-opcode flag.
module tb_insn_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_insn = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_opcode;
    logic       out_util;
    logic [2:0] out_reg;
    logic [7:0] out_imm;
    logic       out_ext;
    logic       out_illegal;
    logic       dbg_state;

    int errors = 0;
    int checks = 0;

    // Observed bundle is {valid, opcode, util, reg, imm, ext}, which is 18 bits.
    logic [17:0] obs;
    assign obs = {out_valid, out_opcode, out_util, out_reg, out_imm, out_ext};

    function automatic logic [17:0] exp_of(input logic v, input logic [3:0] opc,
                                           input logic u, input logic [2:0] r,
                                           input logic [7:0] imm, input logic e);
        return {v, opc, u, r, imm, e};
    endfunction

`ifdef INSN_DECODE_ILLEGAL_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    insn_decode_stage #(
        .ILLEGAL_MASK(16'h0001)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_util(out_util), .out_reg(out_reg),
        .out_imm(out_imm), .out_ext(out_ext), .out_illegal(out_illegal),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if (obs !== 18'h0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, 18'h0);
        end
        checks++;
        if ({out_illegal, dbg_state} !== 2'b00) begin
            errors++; $display("FAIL reset_illegal_state got=%b exp=00", {out_illegal, dbg_state});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_insn = 8'h35;
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== exp_of(1, 4'h3, 0, 3'd5, 8'h05, 0)) begin
            errors++; $display("FAIL basic_35 got=%h exp=%h", obs, exp_of(1, 4'h3, 0, 3'd5, 8'h05, 0));
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_inc2();
        in_valid = 1'b1; in_insn = 8'hE9;
        step();
        checks++;
        if (obs !== exp_of(1, 4'hE, 1, 3'd1, 8'h02, 0)) begin
            errors++; $display("FAIL inc2_E9 got=%h exp=%h", obs, exp_of(1, 4'hE, 1, 3'd1, 8'h02, 0));
        end
        in_insn = 8'h8F;
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== exp_of(1, 4'h8, 1, 3'd7, 8'h0F, 0)) begin
            errors++; $display("FAIL short_8F got=%h exp=%h", obs, exp_of(1, 4'h8, 1, 3'd7, 8'h0F, 0));
        end
        step();
    endtask

    task automatic test_ext();
        in_valid = 1'b1; in_insn = 8'hC2;
        step();
        checks++;
        if ({out_valid, dbg_state} !== 2'b01) begin
            errors++; $display("FAIL ext_first_beat got=%b exp=01", {out_valid, dbg_state});
        end
        in_insn = 8'hA7;
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== exp_of(1, 4'hC, 0, 3'd2, 8'hA7, 1)) begin
            errors++; $display("FAIL ext_pair got=%h exp=%h", obs, exp_of(1, 4'hC, 0, 3'd2, 8'hA7, 1));
        end
        checks++;
        if (dbg_state !== 1'b0) begin
            errors++; $display("FAIL ext_state_return got=%b exp=0", dbg_state);
        end
        step();
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_insn = 8'h35; out_ready = 1'b0;
        step();
        in_insn = 8'hE9;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready);
        end
        step();
        step();
        checks++;
        if (obs !== exp_of(1, 4'h3, 0, 3'd5, 8'h05, 0)) begin
            errors++; $display("FAIL bp_hold got=%h exp=%h", obs, exp_of(1, 4'h3, 0, 3'd5, 8'h05, 0));
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== exp_of(1, 4'hE, 1, 3'd1, 8'h02, 0)) begin
            errors++; $display("FAIL bp_refill got=%h exp=%h", obs, exp_of(1, 4'hE, 1, 3'd1, 8'h02, 0));
        end
        step();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_insn = 8'hC2;
        step();
        flush = 1'b1; in_insn = 8'hA7;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready);
        end
        step();
        checks++;
        if ({out_valid, dbg_state} !== 2'b00) begin
            errors++; $display("FAIL flush_clear got=%b exp=00", {out_valid, dbg_state});
        end
        flush = 1'b0; in_insn = 8'h12;
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== exp_of(1, 4'h1, 0, 3'd2, 8'h02, 0)) begin
            errors++; $display("FAIL flush_next got=%h exp=%h", obs, exp_of(1, 4'h1, 0, 3'd2, 8'h02, 0));
        end
        step();
    endtask

    task automatic test_reset_mid_ext();
        in_valid = 1'b1; in_insn = 8'hC5;
        step();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({obs, dbg_state} !== 19'h0) begin
            errors++; $display("FAIL rst_mid_ext got=%h exp=0", {obs, dbg_state});
        end
        rst_n = 1'b1; in_insn = 8'h12;
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== exp_of(1, 4'h1, 0, 3'd2, 8'h02, 0)) begin
            errors++; $display("FAIL rst_mid_ext_next got=%h exp=%h", obs, exp_of(1, 4'h1, 0, 3'd2, 8'h02, 0));
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vec_in [4];
        logic [17:0] vec_exp [4];
        vec_in[0] = 8'h35; vec_exp[0] = exp_of(1, 4'h3, 0, 3'd5, 8'h05, 0);
        vec_in[1] = 8'hF5; vec_exp[1] = exp_of(1, 4'hF, 0, 3'd5, 8'h02, 0);
        vec_in[2] = 8'h8F; vec_exp[2] = exp_of(1, 4'h8, 1, 3'd7, 8'h0F, 0);
        vec_in[3] = 8'h4A; vec_exp[3] = exp_of(1, 4'h4, 1, 3'd2, 8'h0A, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_insn = vec_in[i];
            step();
            checks++;
            if (obs !== vec_exp[i]) begin
                errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, obs, vec_exp[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_insn = 8'h00;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_illegal, out_imm} !== {1'b1, ILL_EXP, 8'h00}) begin
            errors++; $display("FAIL illegal_00 got=%h exp=%h", {out_valid, out_illegal, out_imm}, {1'b1, ILL_EXP, 8'h00});
        end
        in_valid = 1'b1; in_insn = 8'h35;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_35 got=%b exp=0", out_illegal);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inc2();
        test_ext();
        test_backpressure();
        test_flush();
        test_reset_mid_ext();
        test_back_to_back();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
